// File: rtl/serial_add_arbiter_pkg.sv
// Shared constants for the bit-serial adder arbiter: FSM encoding and requester IDs.
package serial_add_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/serial_add_arbiter_fa_bit.sv
// Single-bit full adder: the one arithmetic cell shared by both requesters.
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    // Plain combinational full-adder equations.
    always_comb begin
        sum_o  = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of a bit-serial (LSB-first) adder built from one
// full-adder cell and a carry flip-flop. One operation takes WIDTH+2 cycles.
module serial_add_arbiter
    import serial_add_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
    logic [WIDTH-1:0] a_shift, b_shift, sum_shift;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             last_q;
    logic             id_q;
    logic             ack0_q, ack1_q, done_q, done_id_q, cout_q;
    logic [WIDTH-1:0] sum_q;

    logic grant_en, shift_en, finish;
    logic grant_id;
    logic fa_sum, fa_cout;

    // Bit 0 of the sum shift register is shifted out on the final edge and never read.
    logic sum_sr_unused;
    assign sum_sr_unused = sum_sr_q[0];

    fa_bit u_fa (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Shift network: operands move right, the fresh sum bit enters at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shift[gi]   = a_sr_q[gi+1];
            assign b_shift[gi]   = b_sr_q[gi+1];
            assign sum_shift[gi] = sum_sr_q[gi+1];
        end
    endgenerate
    assign a_shift[WIDTH-1]   = 1'b0;
    assign b_shift[WIDTH-1]   = 1'b0;
    assign sum_shift[WIDTH-1] = fa_sum;

    // Round-robin pick: on contention serve whoever was not served last.
    assign grant_id = (req0 && req1) ? ~last_q : (req1 ? REQ_ID1 : REQ_ID0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_en = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, serial add, result registers and handshake pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            last_q    <= REQ_ID1;
            id_q      <= REQ_ID0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= REQ_ID0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            ack0_q <= grant_en && (grant_id == REQ_ID0);
            ack1_q <= grant_en && (grant_id == REQ_ID1);
            done_q <= finish;
            if (grant_en) begin
                a_sr_q  <= (grant_id == REQ_ID1) ? a1 : a0;
                b_sr_q  <= (grant_id == REQ_ID1) ? b1 : b0;
                carry_q <= (grant_id == REQ_ID1) ? cin1 : cin0;
                cnt_q   <= '0;
                last_q  <= grant_id;
                id_q    <= grant_id;
            end
            if (shift_en) begin
                a_sr_q   <= a_shift;
                b_sr_q   <= b_shift;
                sum_sr_q <= sum_shift;
                carry_q  <= fa_cout;
                cnt_q    <= cnt_q + 1'b1;
            end
            // The result is captured on the last shift edge so it appears with done.
            if (finish) begin
                sum_q     <= sum_shift;
                cout_q    <= fa_cout;
                done_id_q <= id_q;
            end
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Shares one single-bit full-adder cell between two requesters. Each requester submits WIDTH-bit operand pairs.
- Sequences the cell LSB-first, one bit per clock, with a carry flip-flop between bits.
- Arbitrates round-robin between the requesters and returns the sum, carry-out and the served requester's ID with a done pulse.
- Intended as the area-minimal adder front end for slow control-path arithmetic.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req0  input  1  requester 0 request.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- cin0  input  1  requester 0 carry-in.
- req1  input  1  requester 1 request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- cin1  input  1  requester 1 carry-in.
- ack0  output  1  one-cycle pulse: requester 0's operands captured.
- ack1  output  1  one-cycle pulse: requester 1's operands captured.
- busy  output  1  high while an operation is in flight (SHIFT or DONE).
- done  output  1  one-cycle pulse: result valid.
- done_id  output  1  requester ID for the current/last result.
- sum  output  WIDTH  result sum.
- cout  output  1  result carry-out.

Behaviour:
- Reset values: state=IDLE, ack0=ack1=busy=done=0, sum=0, cout=0, done_id=0, bit counter=0, carry FF=0, last-served pointer=1 (so requester 0 wins the first contention).
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - At an edge with any req high, grant one requester.
  - If both are requesting, grant the one not equal to last-served. If only one is requesting, grant it.
  - On grant, capture the granted a/b into shift registers and its cin into the carry FF. Set counter=0, set last-served=granted ID, go to SHIFT.
  - The granted ack is registered high for exactly the next cycle.
- SHIFT:
  - Each cycle, the full-adder cell adds A[0], B[0] and the carry FF.
  - The sum bit shifts into the MSB of the sum shift register. The carry FF takes carry-out. A and B shift right by one.
  - After the cycle with counter==WIDTH-1, go to DONE.
  - SHIFT lasts exactly WIDTH cycles.
- DONE:
  - Register sum, cout=carry FF and done_id, with done=1 for this single cycle. Then go to IDLE.
- Latency and throughput:
  - Grant edge E0: ack visible in cycle E0..E0+1, done visible in cycle E0+WIDTH..E0+WIDTH+1.
  - Earliest next grant is at edge E0+WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- busy is high from the grant edge until the edge leaving DONE.
- Requests arriving while not in IDLE are neither acked nor queued; the requester holds req until it sees its ack.
- A requester must deassert req in the cycle after ack. If req is still high at the next IDLE edge, that is a new request.
- Outputs sum, cout and done_id hold their last values between done pulses.
- Arithmetic: {cout,sum} equals a+b+cin modulo 2^(WIDTH+1), with no saturation. WIDTH=1 means one SHIFT cycle.
- Reset asserted mid-operation aborts the operation in the next cycle: no done is emitted and all registers return to reset values, including the pointer.
- Operands are sampled only at the grant edge. Later changes on a/b/cin have no effect on the in-flight operation.

Decomposition:
- Shared package holds the FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the requester ID constants.
- One sub-module, fa_bit: a purely combinational single-bit full adder (a,b,cin -> sum,cout), instantiated once.
- Arbiter, counter and shift registers live in the top module.

Test Plan:
- Basic add, WIDTH=8: req0 with a0=8'h5A, b0=8'h3C, cin0=0 -> ack0 one cycle later; done 8 cycles after that with sum=8'h96, cout=0, done_id=0.
- Carry ripple: req1 with a1=8'hFF, b1=8'h01, cin1=0 -> sum=8'h00, cout=1, done_id=1. A second op with 8'hFF+8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Contention after reset: req0 and req1 high on the same edge -> ack0 first; req1 held -> ack1 at the edge WIDTH+2 after the first grant; done_ids are 0 then 1.
- Round-robin fairness: both requesters hold req continuously for 4 operations -> grants alternate 0,1,0,1; no done gap larger than WIDTH+2 cycles.
- Busy rejection: req1 pulsed for 1 cycle during SHIFT -> no ack1; sum and done_id are unaffected.
- Reset mid-operation: rst high for 1 cycle at SHIFT bit 3 -> no done pulse; busy=0, sum=0, cout=0; the next simultaneous request grants requester 0.
